pipeline_ctrl: RTL and testbench

//  Sequences the 5-stage pipeline (IF/ID/EX/MA/WB): turns the hazard unit's o_hz_data,
//  EX branch/jump redirects and memory wait signals into per-stage clock enables and

---
 rtl/pipeline_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the 5-stage IF/ID/EX/MA/WB core: per-stage clock enables,
// bubble strobes, multi-cycle redirect flush, stall watchdog and performance counters.
module pipeline_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 1023,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_hz_data,
    input  logic             i_br_taken,
    input  logic             i_imem_wait,
    input  logic             i_dmem_wait,
    output logic             o_if_ce,
    output logic             o_id_ce,
    output logic             o_ex_ce,
    output logic             o_ma_ce,
    output logic             o_wb_ce,
    output logic             o_id_flush,
    output logic             o_ex_flush,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_redir_cnt
);

    localparam int unsigned FC_W  = 4;
    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned WD_W1 = WD_W + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [FC_W-1:0]  fl_cnt;
    logic [FC_W-1:0]  fl_cnt_nxt;
    logic [WD_W-1:0]  wd_cnt;
    logic [WD_W-1:0]  wd_cnt_nxt;
    logic [WD_W1-1:0] wd_inc;
    logic             wd_stall;
    logic             wd_fire;
    logic             stall_take;
    logic             redir_take;

    assign wd_inc = {1'b0, wd_cnt} + WD_W1'(1);

    // State register, watchdog and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_RUN;
            fl_cnt      <= '0;
            wd_cnt      <= '0;
            o_timeout   <= 1'b0;
            o_stall_cnt <= '0;
            o_redir_cnt <= '0;
        end else begin
            state       <= state_nxt;
            fl_cnt      <= fl_cnt_nxt;
            wd_cnt      <= wd_cnt_nxt;
            o_timeout   <= o_timeout | wd_fire;
            o_stall_cnt <= o_stall_cnt + CNT_W'(stall_take);
            o_redir_cnt <= o_redir_cnt + CNT_W'(redir_take);
        end
    end

    // Next-state: event priority is HALT, dmem freeze, flush, redirect, data stall, fetch wait
    always_comb begin
        state_nxt  = state;
        fl_cnt_nxt = fl_cnt;
        wd_cnt_nxt = wd_cnt;
        wd_stall   = 1'b0;
        wd_fire    = 1'b0;
        stall_take = 1'b0;
        redir_take = 1'b0;
        if (state != ST_HALT) begin
            if (i_dmem_wait) begin
                wd_stall = 1'b1;
            end else if (state == ST_FLUSH) begin
                wd_stall   = i_imem_wait;
                fl_cnt_nxt = fl_cnt - FC_W'(1);
                if (fl_cnt == FC_W'(1)) begin
                    state_nxt = ST_RUN;
                end
            end else if (i_br_taken) begin
                redir_take = 1'b1;
                if (FLUSH_CYCLES > 0) begin
                    fl_cnt_nxt = FC_W'(FLUSH_CYCLES);
                    state_nxt  = ST_FLUSH;
                end
            end else if (i_hz_data) begin
                stall_take = 1'b1;
                wd_stall   = 1'b1;
            end else if (i_imem_wait) begin
                wd_stall = 1'b1;
            end

            if (wd_stall) begin
                wd_cnt_nxt = wd_inc[WD_W-1:0];
                if ((TIMEOUT != 0) && (wd_inc == WD_W1'(TIMEOUT))) begin
                    wd_fire   = 1'b1;
                    state_nxt = ST_HALT;
                end
            end else begin
                wd_cnt_nxt = '0;
            end
        end
    end

    // Zero-latency stage enables and bubble strobes
    always_comb begin
        o_if_ce    = 1'b0;
        o_id_ce    = 1'b0;
        o_ex_ce    = 1'b0;
        o_ma_ce    = 1'b0;
        o_wb_ce    = 1'b0;
        o_id_flush = 1'b0;
        o_ex_flush = 1'b0;
        if (i_rst) begin
            {o_if_ce, o_id_ce, o_ex_ce, o_ma_ce, o_wb_ce} = 5'b11111;
            o_id_flush = 1'b1;
            o_ex_flush = 1'b1;
        end else if (state == ST_HALT || i_dmem_wait) begin
            o_if_ce = 1'b0;
        end else if (state == ST_FLUSH) begin
            {o_if_ce, o_id_ce, o_ex_ce, o_ma_ce, o_wb_ce} = 5'b11111;
            o_id_flush = i_imem_wait;
            o_ex_flush = 1'b1;
        end else if (i_br_taken) begin
            {o_if_ce, o_id_ce, o_ex_ce, o_ma_ce, o_wb_ce} = 5'b11111;
            o_id_flush = 1'b1;
            o_ex_flush = 1'b1;
        end else if (i_hz_data) begin
            {o_ex_ce, o_ma_ce, o_wb_ce} = 3'b111;
            o_ex_flush = 1'b1;
        end else if (i_imem_wait) begin
            {o_id_ce, o_ex_ce, o_ma_ce, o_wb_ce} = 4'b1111;
            o_id_flush = 1'b1;
        end else begin
            {o_if_ce, o_id_ce, o_ex_ce, o_ma_ce, o_wb_ce} = 5'b11111;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized checks of pipeline_ctrl against a cycle-level behavioural model.
module tb_pipeline_ctrl;

    localparam int unsigned FC = 2;
    localparam int unsigned TO = 8;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hz = 1'b0, br = 1'b0, im = 1'b0, dm = 1'b0;
    logic          if_ce, id_ce, ex_ce, ma_ce, wb_ce, id_fl, ex_fl, tmo;
    logic [CW-1:0] stall_cnt, redir_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model state kept as plain integers
    bit       m_halt;
    int       m_fl_left;
    int       m_wd;
    bit       m_to;
    bit [7:0] m_stall;
    bit [7:0] m_redir;

    pipeline_ctrl #(.FLUSH_CYCLES(FC), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_hz_data(hz), .i_br_taken(br),
        .i_imem_wait(im), .i_dmem_wait(dm),
        .o_if_ce(if_ce), .o_id_ce(id_ce), .o_ex_ce(ex_ce), .o_ma_ce(ma_ce),
        .o_wb_ce(wb_ce), .o_id_flush(id_fl), .o_ex_flush(ex_fl),
        .o_timeout(tmo), .o_stall_cnt(stall_cnt), .o_redir_cnt(redir_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {if,id,ex,ma,wb,id_flush,ex_flush} for the current inputs and model state
    function automatic logic [6:0] exp_ctl();
        if (rst)               return 7'b1111111;
        if (m_halt || dm)      return 7'b0000000;
        if (m_fl_left > 0)     return {5'b11111, im, 1'b1};
        if (br)                return 7'b1111111;
        if (hz)                return 7'b0011101;
        if (im)                return 7'b0111110;
        return 7'b1111100;
    endfunction

    task automatic model_update();
        bit stalled;
        stalled = 1'b0;
        if (rst) begin
            m_halt = 0; m_fl_left = 0; m_wd = 0; m_to = 0; m_stall = 0; m_redir = 0;
        end else if (!m_halt) begin
            if (dm) begin
                stalled = 1'b1;
            end else if (m_fl_left > 0) begin
                stalled = im;
                m_fl_left--;
            end else if (br) begin
                m_redir++;
                m_fl_left = FC;
            end else if (hz) begin
                m_stall++;
                stalled = 1'b1;
            end else if (im) begin
                stalled = 1'b1;
            end
            if (stalled) begin
                m_wd++;
                if (TO != 0 && m_wd == TO) begin
                    m_to   = 1'b1;
                    m_halt = 1'b1;
                end
            end else begin
                m_wd = 0;
            end
        end
    endtask

    // One cycle: drive at negedge, check just after, then advance the model
    task automatic step(input logic r, input logic h, input logic b, input logic i, input logic d);
        @(negedge clk);
        rst = r; hz = h; br = b; im = i; dm = d;
        #1;
        chk("ctl", 32'({if_ce, id_ce, ex_ce, ma_ce, wb_ce, id_fl, ex_fl}), 32'(exp_ctl()));
        chk("timeout", 32'(tmo), 32'(m_to));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("redir_cnt", 32'(redir_cnt), 32'(m_redir));
        model_update();
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_halt = 0; m_fl_left = 0; m_wd = 0; m_to = 0; m_stall = 0; m_redir = 0;

        repeat (3) step(1, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);

        repeat (3) step(0, 1, 0, 0, 0);
        after_edge();
        chk("stall_after_3", 32'(stall_cnt), 32'd3);

        step(0, 0, 1, 0, 0);
        repeat (2) step(0, 1, 0, 0, 0);
        after_edge();
        chk("redir_one", 32'(redir_cnt), 32'd1);
        chk("stall_ignored_in_flush", 32'(stall_cnt), 32'd3);
        repeat (2) step(0, 0, 0, 0, 0);

        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 0);

        step(0, 1, 1, 0, 0);
        after_edge();
        chk("br_beats_hz_stall", 32'(stall_cnt), 32'd3);
        chk("br_beats_hz_redir", 32'(redir_cnt), 32'd3);
        repeat (3) step(0, 0, 0, 0, 0);

        repeat (10) step(0, 0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0);
        chk("halt_ctl", 32'({if_ce, id_ce, ex_ce, ma_ce, wb_ce, id_fl, ex_fl}), 32'd0);
        chk("timeout_sticky", 32'(tmo), 32'd1);
        repeat (2) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) < 3,  $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 12);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
